// File: rtl/hc_pkg.sv
// ---------------------------------------------------------------------------
// hc_pkg
// Shared definitions for the Hamming SECDED codec family.
//   hc_cw_wd     : total codeword width (data + check + overall parity)
//   hc_is_pow2   : true for Hamming positions that hold check bits
//   hc_data_pos  : Hamming position (1-based) of data bit idx
//   hc_err_e     : per-beat error classification
// ---------------------------------------------------------------------------
package hc_pkg;

    typedef enum logic [1:0] {
        HC_OK  = 2'd0,
        HC_SGL = 2'd1,
        HC_DBL = 2'd2
    } hc_err_e;

    function automatic int hc_cw_wd(input int data_wd, input int chk_wd);
        return data_wd + chk_wd + 1;
    endfunction

    function automatic bit hc_is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Data bits occupy the non-power-of-two positions in ascending order, so
    // data bit idx sits at the (idx+1)-th such position.
    function automatic int hc_data_pos(input int idx);
        int pos;
        int seen;
        pos  = 0;
        seen = -1;
        while (seen < idx) begin
            pos++;
            if (!hc_is_pow2(pos)) begin
                seen++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hc_syndrome.sv
// ---------------------------------------------------------------------------
// hc_syndrome
// Combinational Hamming syndrome and overall-parity calculation. Shared with
// the encoder side of the codec.
// Ports:
//   code : received codeword, bit p-1 = Hamming position p, MSB = overall parity
//   syn  : syndrome, the position of a single flipped bit (0 when consistent)
//   par  : XOR of every codeword bit including the overall-parity bit
// ---------------------------------------------------------------------------
module hc_syndrome
    import hc_pkg::*;
#(
    parameter int DATA_WD = 4,
    parameter int CHK_WD  = 3
) (
    input  logic [hc_cw_wd(DATA_WD, CHK_WD)-1:0] code,
    output logic [CHK_WD-1:0]                    syn,
    output logic                                 par
);

    localparam int N = DATA_WD + CHK_WD;

    // Each set bit contributes its own position number to the syndrome, so a
    // lone flipped bit leaves exactly its position behind.
    always_comb begin
        syn = '0;
        for (int p = 1; p <= N; p++) begin
            if (code[p-1]) begin
                syn = syn ^ CHK_WD'(p);
            end
        end
        par = ^code;
    end

endmodule

// File: rtl/hc_secded_dec.sv
// ---------------------------------------------------------------------------
// hc_secded_dec
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshaking and
// saturating error counters.
//   S1 captures the codeword together with its syndrome and parity flag.
//   S2 holds the corrected data and the error flags presented downstream.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_valid/o_ready       : input codeword handshake
//   i_code                : received codeword (data, check bits, parity MSB)
//   i_inj_mask            : error-injection XOR mask (only with HC_ERR_INJ_EN)
//   o_valid/i_ready       : output beat handshake
//   o_data                : corrected (or raw, if uncorrectable) data
//   o_err_single          : beat carried a corrected single-bit error
//   o_err_double          : beat is uncorrectable
//   i_cnt_clr             : clear both counters (wins over an increment)
//   o_cnt_single/double   : saturating counts of delivered error beats
// Build option:
//   HC_ERR_INJ_EN         : adds i_inj_mask, XORed into the codeword at capture
// ---------------------------------------------------------------------------
module hc_secded_dec
    import hc_pkg::*;
#(
    parameter int DATA_WD = 4,
    parameter int CHK_WD  = 3,
    parameter int CNT_WD  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [DATA_WD+CHK_WD:0]    i_code,
`ifdef HC_ERR_INJ_EN
    input  logic [DATA_WD+CHK_WD:0]    i_inj_mask,
`endif
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_WD-1:0]         o_data,
    output logic                       o_err_single,
    output logic                       o_err_double,
    input  logic                       i_cnt_clr,
    output logic [CNT_WD-1:0]          o_cnt_single,
    output logic [CNT_WD-1:0]          o_cnt_double
);

    localparam int N  = DATA_WD + CHK_WD;
    localparam int CW = hc_cw_wd(DATA_WD, CHK_WD);

    generate
        if ((2 ** CHK_WD) < (N + 1)) begin : g_chk_wd_bad
            $error("hc_secded_dec: CHK_WD=%0d too small for DATA_WD=%0d", CHK_WD, DATA_WD);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s1_valid;
    logic s1_load;
    logic s2_load;

    assign s2_load = !o_valid || i_ready;
    assign s1_load = !s1_valid || s2_load;
    assign o_ready = s1_load;

    // ---------------------------------------------------------------------
    // Stage 1: capture codeword, syndrome and parity
    // ---------------------------------------------------------------------
    logic [CW-1:0]     cap_code;
    logic [CHK_WD-1:0] cap_syn;
    logic              cap_par;

`ifdef HC_ERR_INJ_EN
    assign cap_code = i_code ^ i_inj_mask;
`else
    assign cap_code = i_code;
`endif

    hc_syndrome #(
        .DATA_WD (DATA_WD),
        .CHK_WD  (CHK_WD)
    ) u_syndrome (
        .code (cap_code),
        .syn  (cap_syn),
        .par  (cap_par)
    );

    logic [CW-1:0]     s1_code;
    logic [CHK_WD-1:0] s1_syn;
    logic              s1_par;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_code <= cap_code;
                s1_syn  <= cap_syn;
                s1_par  <= cap_par;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Classification and correction from S1 contents
    // ---------------------------------------------------------------------
    hc_err_e           s1_kind;
    logic [CW-1:0]     s1_fixed;
    logic [DATA_WD-1:0] s1_data;

    always_comb begin
        s1_fixed = s1_code;
        s1_kind  = HC_OK;
        if (s1_syn == '0) begin
            // Only the overall-parity bit can be wrong; data is untouched.
            if (s1_par) begin
                s1_kind = HC_SGL;
            end
        end else if (s1_par) begin
            // Odd error count with a syndrome beyond the codeword cannot be a
            // single flip.
            if (int'(s1_syn) > N) begin
                s1_kind = HC_DBL;
            end else begin
                s1_kind = HC_SGL;
                for (int p = 1; p <= N; p++) begin
                    if (s1_syn == CHK_WD'(p)) begin
                        s1_fixed[p-1] = ~s1_code[p-1];
                    end
                end
            end
        end else begin
            s1_kind = HC_DBL;
        end
    end

    for (genvar g = 0; g < DATA_WD; g++) begin : g_extract
        localparam int POS = hc_data_pos(g);
        assign s1_data[g] = s1_fixed[POS-1];
    end

    // ---------------------------------------------------------------------
    // Stage 2: output register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_err_single <= 1'b0;
            o_err_double <= 1'b0;
        end else if (s2_load) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data       <= s1_data;
                o_err_single <= (s1_kind == HC_SGL);
                o_err_double <= (s1_kind == HC_DBL);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Saturating error counters, advanced on delivered beats only
    // ---------------------------------------------------------------------
    logic out_fire;
    assign out_fire = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cnt_single <= '0;
            o_cnt_double <= '0;
        end else if (i_cnt_clr) begin
            o_cnt_single <= '0;
            o_cnt_double <= '0;
        end else begin
            if (out_fire && o_err_single && (o_cnt_single != '1)) begin
                o_cnt_single <= o_cnt_single + 1'b1;
            end
            if (out_fire && o_err_double && (o_cnt_double != '1)) begin
                o_cnt_double <= o_cnt_double + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hc_secded_dec.sv
// ---------------------------------------------------------------------------
// tb_hc_secded_dec
// Self-checking bench for hc_secded_dec (DATA_WD=4, CHK_WD=3). A second
// instance with CNT_WD=2 exercises counter saturation and clear priority.
// ---------------------------------------------------------------------------
module tb_hc_secded_dec;

    localparam int DW = 4;
    localparam int CK = 3;
    localparam int CWW = DW + CK + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid;
    logic           dec_ready;
    logic [CWW-1:0] in_code;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic           out_sgl;
    logic           out_dbl;
    logic           cnt_clr;
    logic [15:0]    cnt_sgl;
    logic [15:0]    cnt_dbl;

    logic           s_valid;
    logic           s_dec_ready;
    logic [CWW-1:0] s_code;
    logic           s_out_valid;
    logic           s_out_ready;
    logic [DW-1:0]  s_data;
    logic           s_sgl;
    logic           s_dbl;
    logic           s_clr;
    logic [1:0]     s_cnt_sgl;
    logic [1:0]     s_cnt_dbl;

`ifdef HC_ERR_INJ_EN
    logic [CWW-1:0] inj_mask = '0;
`endif

    hc_secded_dec #(.DATA_WD(DW), .CHK_WD(CK), .CNT_WD(16)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (in_valid),
        .o_ready      (dec_ready),
        .i_code       (in_code),
`ifdef HC_ERR_INJ_EN
        .i_inj_mask   (inj_mask),
`endif
        .o_valid      (out_valid),
        .i_ready      (out_ready),
        .o_data       (out_data),
        .o_err_single (out_sgl),
        .o_err_double (out_dbl),
        .i_cnt_clr    (cnt_clr),
        .o_cnt_single (cnt_sgl),
        .o_cnt_double (cnt_dbl)
    );

    hc_secded_dec #(.DATA_WD(DW), .CHK_WD(CK), .CNT_WD(2)) u_sat (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (s_valid),
        .o_ready      (s_dec_ready),
        .i_code       (s_code),
`ifdef HC_ERR_INJ_EN
        .i_inj_mask   (inj_mask),
`endif
        .o_valid      (s_out_valid),
        .i_ready      (s_out_ready),
        .o_data       (s_data),
        .o_err_single (s_sgl),
        .o_err_double (s_dbl),
        .i_cnt_clr    (s_clr),
        .o_cnt_single (s_cnt_sgl),
        .o_cnt_double (s_cnt_dbl)
    );

    int errors = 0;
    int checks = 0;
    int exp_cnt_s = 0;
    int exp_cnt_d = 0;

    typedef struct {
        logic [CWW-1:0] code;
        logic [DW-1:0]  data;
        logic           sgl;
        logic           dbl;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          sgl;
        logic          dbl;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Reference encoder built from the Hamming definitions.
    function automatic logic [CWW-1:0] encode(input logic [DW-1:0] d);
        logic [CWW-1:0] cw;
        int di;
        cw = '0;
        di = 0;
        for (int p = 1; p <= DW + CK; p++) begin
            if (!is_pow2(p)) begin
                cw[p-1] = d[di];
                di++;
            end
        end
        for (int k = 0; k < CK; k++) begin
            logic pb;
            pb = 1'b0;
            for (int p = 1; p <= DW + CK; p++) begin
                if (!is_pow2(p) && (((p >> k) & 1) == 1)) pb = pb ^ cw[p-1];
            end
            cw[(1 << k) - 1] = pb;
        end
        cw[CWW-1] = ^cw[CWW-2:0];
        return cw;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [CWW-1:0] cw);
        logic [DW-1:0] d;
        int di;
        d = '0;
        di = 0;
        for (int p = 1; p <= DW + CK; p++) begin
            if (!is_pow2(p)) begin
                d[di] = cw[p-1];
                di++;
            end
        end
        return d;
    endfunction

    // Single directed beat, always-ready downstream: checks latency, flags
    // and counter update on the handshake.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = v.code;
        #1 check("vec_o_ready", dec_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("vec_o_valid", out_valid, 1);
        check("vec_data", out_data, v.data);
        check("vec_err_single", out_sgl, v.sgl);
        check("vec_err_double", out_dbl, v.dbl);
        if (v.sgl) exp_cnt_s++;
        if (v.dbl) exp_cnt_d++;
        @(negedge clk);
        check("vec_drain", out_valid, 0);
        check("vec_cnt_single", cnt_sgl, exp_cnt_s);
        check("vec_cnt_double", cnt_dbl, exp_cnt_d);
    endtask

    // Streaming run against a queue scoreboard.
    // mode 0: always ready, 1: ready low for 3 cycles mid-stream, 2: random.
    task automatic run_stream(input int nbeats, input int mode, input bit clean_seq);
        exp_t q[$];
        exp_t pend;
        exp_t got;
        int sent;
        int cyc;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        logic prev_s, prev_d;
        bit in_fire, out_fire;
        sent = 0;
        cyc = 0;
        prev_stall = 0;
        prev_data = '0;
        prev_s = 0;
        prev_d = 0;
        while ((sent < nbeats || q.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_single", out_sgl, prev_s);
                check("stall_double", out_dbl, prev_d);
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = !(cyc >= 4 && cyc <= 6);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (sent < nbeats && (mode != 2 || $urandom_range(0, 4) != 0)) begin
                logic [DW-1:0] d;
                logic [CWW-1:0] cw;
                int k, b1, b2;
                d  = clean_seq ? DW'(sent + 1) : DW'($urandom);
                cw = encode(d);
                k  = clean_seq ? 0 : $urandom_range(0, 2);
                b1 = $urandom_range(0, CWW - 1);
                b2 = (b1 + $urandom_range(1, CWW - 1)) % CWW;
                if (k >= 1) cw[b1] = ~cw[b1];
                if (k == 2) cw[b2] = ~cw[b2];
                pend.data = (k == 2) ? extract(cw) : d;
                pend.sgl  = (k == 1);
                pend.dbl  = (k == 2);
                in_valid  = 1'b1;
                in_code   = cw;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("stream_o_ready", dec_ready, (q.size() < 2) || out_ready);
            in_fire  = in_valid && dec_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (q.size() == 0) begin
                    check("stream_spurious_beat", 1, 0);
                end else begin
                    got = q.pop_front();
                    check("stream_data", out_data, got.data);
                    check("stream_err_single", out_sgl, got.sgl);
                    check("stream_err_double", out_dbl, got.dbl);
                    if (got.sgl && exp_cnt_s < 65535) exp_cnt_s++;
                    if (got.dbl && exp_cnt_d < 65535) exp_cnt_d++;
                end
            end
            if (in_fire) begin
                q.push_back(pend);
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_s     = out_sgl;
            prev_d     = out_dbl;
            cyc++;
        end
        if (cyc >= 2000) check("stream_timeout", 1, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_no_extra", out_valid, 0);
        check("stream_cnt_single", cnt_sgl, exp_cnt_s);
        check("stream_cnt_double", cnt_dbl, exp_cnt_d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{8'h55, 4'hB, 1'b0, 1'b0};
        vecs[1] = '{8'h45, 4'hB, 1'b1, 1'b0};
        vecs[2] = '{8'hD5, 4'hB, 1'b1, 1'b0};
        vecs[3] = '{8'h56, 4'hB, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 4'h0, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 4'hF, 1'b0, 1'b0};
        vecs[6] = '{8'h54, 4'hB, 1'b1, 1'b0};
        vecs[7] = '{8'h15, 4'hB, 1'b1, 1'b0};
        vecs[8] = '{8'h65, 4'hD, 1'b0, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_code = '0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        s_valid = 1'b0;
        s_code = '0;
        s_out_ready = 1'b1;
        s_clr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_o_valid", out_valid, 0);
        check("rst_o_data", out_data, 0);
        check("rst_err_single", out_sgl, 0);
        check("rst_err_double", out_dbl, 0);
        check("rst_cnt_single", cnt_sgl, 0);
        check("rst_cnt_double", cnt_dbl, 0);
        rst = 1'b0;
        out_ready = 1'b0;
        #1 check("rst_o_ready", dec_ready, 1);
        out_ready = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        run_stream(5, 1, 1'b1);
        run_stream(60, 2, 1'b0);
        run_stream(20, 0, 1'b0);

        // Reset with a beat in flight discards it.
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 8'h45;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt_s = 0;
        exp_cnt_d = 0;
        for (int i = 0; i < 3; i++) begin
            check("midrst_o_valid", out_valid, 0);
            @(negedge clk);
        end
        check("midrst_cnt_single", cnt_sgl, 0);

        // Counter saturation and clear priority on the CNT_WD=2 instance.
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_code  = 8'h45;
            @(negedge clk);
        end
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sat_cnt_single", s_cnt_sgl, 3);
        check("sat_cnt_double", s_cnt_dbl, 0);
        s_valid = 1'b1;
        s_code  = 8'h45;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        check("clr_o_valid", s_out_valid, 1);
        check("clr_err_single", s_sgl, 1);
        s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
        check("clr_cnt_single", s_cnt_sgl, 0);
        s_valid = 1'b1;
        s_code  = 8'h56;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("post_clr_cnt_double", s_cnt_dbl, 1);
        check("post_clr_cnt_single", s_cnt_sgl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hc_secded_dec.md
Name: hc_secded_dec

Overview:
Parametrised, pipelined Hamming SECDED decoder and the successor to the combinational Hamming encoder. It accepts codewords of DATA_WD data bits, CHK_WD Hamming check bits and one overall-parity bit. It corrects single-bit errors, detects double-bit errors, and returns the data with status over a valid/ready stream. It sits on the receive side of protected links and memories, and keeps saturating error counters for software.

Parameters:
DATA_WD, 4, data bits per codeword.
CHK_WD, 3, Hamming check bits; elaboration $error unless 2**CHK_WD >= DATA_WD+CHK_WD+1.
CNT_WD, 16, width of each error counter.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  input codeword valid
o_ready  output  1  decoder can accept a codeword
i_code  input  DATA_WD+CHK_WD+1  received codeword
o_valid  output  1  decoded beat valid
i_ready  input  1  downstream accepts the beat
o_data  output  DATA_WD  corrected data
o_err_single  output  1  beat had a single error, now corrected (includes an error in the overall-parity bit)
o_err_double  output  1  beat is uncorrectable; data passed through raw
i_cnt_clr  input  1  clear both counters
o_cnt_single  output  CNT_WD  saturating count of single errors
o_cnt_double  output  CNT_WD  saturating count of double errors

Behaviour:
- Codeword layout:
  - Hamming position p (1..N, N=DATA_WD+CHK_WD) is bit p-1 of i_code.
  - Power-of-two positions hold check bits.
  - Data bits fill the remaining positions in ascending order.
  - Bit N is the overall even parity over bits N-1..0.
- Stage 1 (S1):
  - On load, registers the codeword, syndrome s (CHK_WD bits) and parity flag q (XOR of all N+1 bits).
- Stage 2 (S2):
  - On load, registers corrected data and flags from S1.
- Classification from S1 contents:
  - s==0, q==0: clean; no flags.
  - s==0, q==1: overall-parity bit flipped; data intact; err_single=1.
  - s!=0, q==1, s<=N: flip bit s-1, extract data; err_single=1.
  - s!=0, q==1, s>N: invalid position; err_double=1; raw data.
  - s!=0, q==0: err_double=1; raw data extracted uncorrected.
- Handshake:
  - s2_load = !o_valid || i_ready.
  - s1_load = !s1_valid || s2_load.
  - o_ready = s1_load (combinational from i_ready).
  - Accept on i_valid && o_ready.
  - o_valid, o_data and flags hold stable while o_valid && !i_ready.
- Latency and throughput:
  - Latency is 2 cycles from accept to o_valid.
  - Full throughput of 1 beat/cycle while i_ready=1.
  - Bubbles collapse.
- Counters:
  - Update only on an output handshake (o_valid && i_ready) with the matching flag set.
  - Saturate at all-ones; no wrap.
  - i_cnt_clr has priority over a same-cycle increment: result is 0.
- Reset:
  - Clears s1_valid, o_valid, o_data, both flags and both counters to 0.
  - Reset mid-stream discards in-flight beats.
  - o_ready is 1 in the first cycle after reset.

Optional Feature:
HC_ERR_INJ_EN
- Defined: adds input i_inj_mask [DATA_WD+CHK_WD:0]. It is XORed into i_code at S1 capture, allowing errors to be forced on clean traffic.
- Undefined: the port is absent and the codeword is captured unmodified.

Decomposition:
- Package hc_pkg:
  - function hc_cw_wd(DATA_WD, CHK_WD).
  - function hc_is_pow2(pos).
  - function hc_data_pos(idx), mapping data index to Hamming position.
  - typedef enum logic [1:0] hc_err_e {HC_OK, HC_SGL, HC_DBL}.
- Sub-module hc_syndrome: combinational syndrome and overall-parity calculation, reusable by the encoder.

Test Plan:
- DATA_WD=4, CHK_WD=3; i_code=8'h55, i_ready=1 -> 2 cycles later o_data=4'hB, both flags 0, counters unchanged.
- i_code=8'h45 (position 5 flipped) -> o_data=4'hB, o_err_single=1; o_cnt_single increments by 1 on handshake.
- i_code=8'hD5 (overall-parity bit flipped) -> o_data=4'hB, o_err_single=1.
- i_code=8'h56 (bits 0 and 1 flipped) -> o_err_double=1, o_err_single=0, o_cnt_double=1.
- Backpressure: stream 5 distinct clean beats with i_ready low for 3 cycles mid-stream -> no loss or duplication, order preserved, outputs stable while stalled, o_ready low once both stages are full.
- CNT_WD=2: 5 single-error beats -> o_cnt_single saturates at 3. Then i_cnt_clr with a same-cycle error beat -> counter reads 0.
